ship_motion_ctrl: RTL
=====================

// Module: ship_motion_ctrl
// PURPOSE
//  Per-ship behaviour sequencer. Converts player commands into the ship_state code, position and HP that drive one Ship sprite instance.
//  Sits between the keyboard/command decoder and the sprite renderer. Updates once per video frame; all other cycles hold.
// PARAMETERS
//  X_INIT        10'd320  reset/revive X centre
//  Y_INIT        10'd240  fixed Y centre (Ball_Y_Pos constant)
//  X_MIN         10'd40   lowest legal X centre (HALF_LENGTH of sprite)
//  X_MAX         10'd599  highest legal X centre
//  STEP          10'd4    pixels moved per frame in a move state
//  ATTACK_FRAMES 6'd24    frames an attack lasts
//  STRIKE_FRAME  6'd12    frame index inside attack where damage strobe fires
//  HIT_FRAMES    6'd16    frames of get-hit recoil / invulnerability
//  HP_INIT       4'd5     starting hit points
// PORTS
//  Clk          in   1   50 MHz system clock
//  Reset        in   1   asynchronous, active-high reset
//  frame_clk    in   1   ~60 Hz frame signal (asynchronous to Clk)
//  cmd_left     in   1   level: move left requested
//  cmd_right    in   1   level: move right requested
//  cmd_attack   in   1   level: attack requested
//  hit_in       in   1   level: ship struck by opponent this frame
//  revive       in   1   level: leave DEAD, restore HP/position
//  ship_state   out  6   behaviour code to sprite (see encoding)
//  Ball_X_Pos   out  10  ship centre X
//  Ball_Y_Pos   out  10  ship centre Y (= Y_INIT)
//  hp           out  4   remaining hit points
//  anim_cnt     out  6   frames elapsed in current state, saturates at 63
//  strike       out  1   one-Clk pulse at attack STRIKE_FRAME
//  is_dead      out  1   high while in DEAD
// BEHAVIOUR
//  Clocking: all regs on posedge Clk, async clear on Reset.
//  Frame tick: frame_clk -> f1 -> f2 -> f3 flops; tick = f2 & ~f3 (one Clk wide, 3 Clk after frame_clk rise). Only tick cycles change state.
//  Encoding: STAND=0, MOVE_LEFT=1, MOVE_RIGHT=2, ATTACK=3, GET_HIT=4, DEAD=5. Codes 6..63 never driven.
//  Reset values: ship_state=0, Ball_X_Pos=X_INIT, Ball_Y_Pos=Y_INIT, hp=HP_INIT, anim_cnt=0, strike=0, is_dead=0, f1..f3=0.
//  Transitions (evaluated on tick, priority top-down):
//   DEAD: revive -> STAND, hp=HP_INIT, X=X_INIT; else stay (all cmds/hit ignored).
//   GET_HIT: anim_cnt==HIT_FRAMES-1 -> STAND; hit_in ignored (invulnerable).
//   any other state, hit_in=1: hp==1 -> DEAD, hp=0; else GET_HIT, hp=hp-1.
//   ATTACK: anim_cnt==ATTACK_FRAMES-1 -> STAND; move cmds ignored; cmd_attack ignored.
//   STAND/MOVE_*: cmd_attack -> ATTACK; else cmd_right -> MOVE_RIGHT; else cmd_left -> MOVE_LEFT; else STAND.
//   cmd_left & cmd_right together: MOVE_RIGHT wins.
//  anim_cnt: cleared to 0 on tick where state changes; else +1 per tick, saturating at 63. Not advanced in DEAD.
//  Position: on tick where state (after transition) is MOVE_RIGHT: X=min(X+STEP, X_MAX); MOVE_LEFT: X=max(X-STEP, X_MIN).
//   Comparison in 11-bit unsigned before truncation; no wrap below 0 or above 1023.
//  strike: pulses high for the single tick cycle where state==ATTACK and anim_cnt==STRIKE_FRAME-1 (i.e. count becomes STRIKE_FRAME).
//   Hit during ATTACK before strike frame aborts attack; no strike issued.
//  hp never underflows; hp==0 iff DEAD. is_dead = (ship_state==DEAD), registered.
//  Reset mid-frame or mid-attack: immediate return to reset values; pending tick discarded.
//  frame_clk stuck high/low: no ticks, outputs hold indefinitely.
// TESTING
//  1 Reset, 5 frames no cmds -> ship_state=0, X=320, Y=240, hp=5, anim_cnt=5, strike never high.
//  2 cmd_right held 10 frames from X=320 -> state=2, X=360; held until X_MAX -> X stops at 599, never wraps.
//  3 cmd_left from X=44 for 3 frames -> X=40,40,40; left+right together -> state=2.
//  4 cmd_attack 1 frame -> state=3 for 24 frames, single strike pulse exactly 12 ticks after entry, cmd_left during attack ignored, then state=0.
//  5 hit_in 5 times spaced >16 frames -> hp 4,3,2,1 with state=4 each, fifth -> state=5, hp=0, is_dead=1; hit_in in GET_HIT leaves hp unchanged.
//  6 In DEAD assert revive -> state=0, hp=5, X=320; assert Reset during ATTACK -> all outputs to reset values same cycle.

Source files
------------

// File: rtl/ship_motion_ctrl.sv
// Per-ship behaviour sequencer: turns player commands into sprite state, X position and HP.
// Updates only on a synchronised frame tick (3 Clk after frame_clk rises); all other cycles hold.
module ship_motion_ctrl #(
    parameter logic [9:0] X_INIT        = 10'd320,
    parameter logic [9:0] Y_INIT        = 10'd240,
    parameter logic [9:0] X_MIN         = 10'd40,
    parameter logic [9:0] X_MAX         = 10'd599,
    parameter logic [9:0] STEP          = 10'd4,
    parameter logic [5:0] ATTACK_FRAMES = 6'd24,
    parameter logic [5:0] STRIKE_FRAME  = 6'd12,
    parameter logic [5:0] HIT_FRAMES    = 6'd16,
    parameter logic [3:0] HP_INIT       = 4'd5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       cmd_left,
    input  logic       cmd_right,
    input  logic       cmd_attack,
    input  logic       hit_in,
    input  logic       revive,
    output logic [5:0] ship_state,
    output logic [9:0] Ball_X_Pos,
    output logic [9:0] Ball_Y_Pos,
    output logic [3:0] hp,
    output logic [5:0] anim_cnt,
    output logic       strike,
    output logic       is_dead
);

    typedef enum logic [2:0] {
        ST_STAND      = 3'd0,
        ST_MOVE_LEFT  = 3'd1,
        ST_MOVE_RIGHT = 3'd2,
        ST_ATTACK     = 3'd3,
        ST_GET_HIT    = 3'd4,
        ST_DEAD       = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic        f1, f2, f3;
    logic        tick;
    logic [9:0]  x_q, x_nxt;
    logic [3:0]  hp_q, hp_nxt;
    logic [5:0]  anim_q, anim_nxt;
    logic        strike_nxt;
    logic [10:0] x_inc;

    assign tick = f2 & ~f3;

    always_comb begin
        state_nxt  = state;
        hp_nxt     = hp_q;
        x_nxt      = x_q;
        anim_nxt   = anim_q;
        strike_nxt = 1'b0;
        x_inc      = {1'b0, x_q} + {1'b0, STEP};

        case (state)
            ST_DEAD: begin
                if (revive) begin
                    state_nxt = ST_STAND;
                    hp_nxt    = HP_INIT;
                    x_nxt     = X_INIT;
                end
            end
            ST_GET_HIT: begin
                if (anim_q == HIT_FRAMES - 6'd1)
                    state_nxt = ST_STAND;
            end
            default: begin
                if (hit_in) begin
                    if (hp_q == 4'd1) begin
                        state_nxt = ST_DEAD;
                        hp_nxt    = 4'd0;
                    end else begin
                        state_nxt = ST_GET_HIT;
                        hp_nxt    = hp_q - 4'd1;
                    end
                end else if (state == ST_ATTACK) begin
                    if (anim_q == ATTACK_FRAMES - 6'd1)
                        state_nxt = ST_STAND;
                end else if (cmd_attack) begin
                    state_nxt = ST_ATTACK;
                end else if (cmd_right) begin
                    state_nxt = ST_MOVE_RIGHT;
                end else if (cmd_left) begin
                    state_nxt = ST_MOVE_LEFT;
                end else begin
                    state_nxt = ST_STAND;
                end
            end
        endcase

        // Clamp in 11 bits so neither edge can wrap the 10-bit coordinate
        if (state_nxt == ST_MOVE_RIGHT)
            x_nxt = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];
        else if (state_nxt == ST_MOVE_LEFT)
            x_nxt = ({1'b0, x_q} < ({1'b0, X_MIN} + {1'b0, STEP})) ? X_MIN : x_q - STEP;

        if (state_nxt != state)
            anim_nxt = 6'd0;
        else if (state != ST_DEAD && anim_q != 6'd63)
            anim_nxt = anim_q + 6'd1;

        strike_nxt = (state == ST_ATTACK) && (state_nxt == ST_ATTACK) &&
                     (anim_q == STRIKE_FRAME - 6'd1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            f1      <= 1'b0;
            f2      <= 1'b0;
            f3      <= 1'b0;
            state   <= ST_STAND;
            x_q     <= X_INIT;
            hp_q    <= HP_INIT;
            anim_q  <= 6'd0;
            strike  <= 1'b0;
            is_dead <= 1'b0;
        end else begin
            f1     <= frame_clk;
            f2     <= f1;
            f3     <= f2;
            strike <= 1'b0;
            if (tick) begin
                state   <= state_nxt;
                x_q     <= x_nxt;
                hp_q    <= hp_nxt;
                anim_q  <= anim_nxt;
                strike  <= strike_nxt;
                is_dead <= (state_nxt == ST_DEAD);
            end
        end
    end

    assign ship_state = {3'b000, state};
    assign Ball_X_Pos = x_q;
    assign Ball_Y_Pos = Y_INIT;
    assign hp         = hp_q;
    assign anim_cnt   = anim_q;

endmodule
